icache_mem_arbiter: RTL and testbench
=====================================

Name: icache_mem_arbiter

Overview:
- Responder end of the instruction side of cache_control_if.
- Accepts iREN/iaddr fetch requests from NCPU icaches, arbitrates round-robin, and issues one RAM read at a time.
- Returns data to the winning icache with a single-cycle iwait-low/iload pulse.
- Sits in memory control between the per-CPU icaches and the shared RAM port.
- Yields to the data side when it holds RAM.

Parameters:
- NCPU, 2, number of icache requesters (1..4).
- RST_PTR, NCPU-1, reset value of the round-robin last-grant pointer, so CPU0 wins first.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  NCPU  per-CPU fetch request; held high by the icache while it waits.
- iaddr  in  NCPU x 32  per-CPU word address (word_t).
- iwait  out  NCPU  per-CPU wait; low for exactly one cycle when data is valid.
- iload  out  NCPU x 32  per-CPU returned instruction; valid only while the matching iwait is low.
- dbusy  in  1  data side owns RAM this cycle; the instruction side must not drive RAM.
- ramREN  out  1  RAM read enable.
- ramaddr  out  32  RAM address.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

Behaviour:
- Reset (RST high, asynchronous):
  - state = IDLE; last-grant pointer = RST_PTR; latched id = 0; latched addr = 0.
  - Outputs: all iwait = 1, all iload = 0, ramREN = 0, ramaddr = 0.
- States (arb_state_t): IDLE, FETCH, RETRY.
- IDLE:
  - ramREN = 0.
  - If dbusy = 0 and any iREN is set: round-robin pick of the first requester after the last-grant pointer.
  - Latch winner id and iaddr[winner]; next state = FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - ramREN = 1, ramaddr = latched addr.
  - Priority of conditions, highest first:
    1. dbusy = 1 -> abort: ramREN = 0 this cycle, go IDLE, pointer unchanged.
    2. iREN[id] = 0 -> requester abandoned the fetch: go IDLE, pointer unchanged, no iwait pulse.
    3. iaddr[id] != latched addr -> stale request: go IDLE, pointer unchanged; the request is re-arbitrated next cycle.
    4. ramstate = ACCESS -> combinationally iwait[id] = 0 and iload[id] = ramload this same cycle; pointer = id; go IDLE.
    5. ramstate = ERROR -> go RETRY.
    6. FREE or BUSY -> stay in FETCH.
- RETRY:
  - ramREN = 0 for exactly one cycle, then go FETCH with the same id and addr.
  - The abort checks of FETCH (dbusy, iREN, address mismatch) also apply in RETRY.
- Latency:
  - Request seen in IDLE at cycle N; ramREN high at N+1.
  - Earliest data at N+1 if RAM returns ACCESS immediately.
  - Back-to-back: IDLE is always one cycle between grants (fairness point).
- Outputs are never asserted for non-winners: iwait[k] = 1 and iload[k] = 0 for every k != id, and for every k outside the ACCESS cycle.
- Simultaneous events:
  - ACCESS together with dbusy: dbusy wins, no data is delivered.
  - ACCESS together with iREN[id] dropping: no delivery.
- RST mid-FETCH: immediate return to the reset values above; the RAM read is simply dropped.
- Pointer wrap: after NCPU-1 the search continues at 0.

Optional Feature:
- Macro: IARB_PERF_EN.
- Defined:
  - Adds output grant_cnt (NCPU x 32), incremented on each ACCESS delivery to that CPU.
  - Adds output stall_cnt (32), incremented on every cycle with any iREN set and no delivery.
  - Both counters are cleared by RST and saturate at 32'hFFFFFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- cpu_types_pkg: word_t, ramstate_t (already present); add arb_state_t {IDLE, FETCH, RETRY}.
- One sub-module: rr_arbiter.
  - Parameter NCPU.
  - Inputs: req vector, last-grant pointer.
  - Outputs: grant id, any-valid flag.
  - Purely combinational; reused later for the data side.

Test Plan:
- Single fetch: CPU0 iREN = 1, iaddr = 32'h40; RAM BUSY 3 cycles then ACCESS with ramload = 32'hDEADBEEF -> ramaddr = 32'h40, iwait[0] low one cycle with iload[0] = 32'hDEADBEEF, iwait[1] stays 1.
- Fairness: CPU0 and CPU1 request continuously; RAM returns ACCESS every FETCH cycle -> grant order 0, 1, 0, 1, with exactly one IDLE cycle between grants.
- Abandon: CPU1 in FETCH, iREN[1] drops while RAM is BUSY -> ramREN falls next cycle, no iwait[1] pulse, pointer unchanged, so CPU1 is still next in line.
- Data preemption: dbusy asserted in the same cycle ramstate = ACCESS -> no iwait pulse, state IDLE; after dbusy falls the same CPU is re-granted with the same address.
- ERROR path: ramstate = ERROR once, then ACCESS -> ramREN low for exactly one cycle, then the same ramaddr reissued and data delivered.
- Async reset: RST asserted mid-FETCH between clock edges -> ramREN = 0 and all iwait = 1 immediately; the first grant after release goes to CPU0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
//   Shared types for the memory-control slice.
//     word_t      : 32-bit machine word / word address
//     ramstate_t  : RAM port status (FREE, BUSY, ACCESS, ERROR)
//     arb_state_t : instruction-side arbiter states (IDLE, FETCH, RETRY)
//   id_width() gives the width of a requester index; it never returns 0,
//   so a single-requester build still has a 1-bit index.
// ---------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RETRY = 2'd2
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// icache_mem_arbiter_if
//   Instruction side of cache_control_if plus the shared RAM port.
//   Parameter NCPU : number of icache requesters.
//   Signals:
//     iREN     [NCPU]     per-CPU fetch request
//     iaddr    [NCPU]x32  per-CPU word address
//     iwait    [NCPU]     per-CPU wait, low one cycle when data is valid
//     iload    [NCPU]x32  per-CPU returned instruction
//     dbusy               data side owns RAM this cycle
//     ramREN / ramaddr    RAM read request
//     ramload / ramstate  RAM read data and status
//   Modports: slave  = arbiter (responder) side
//             master = icaches + RAM side (driver of requests/RAM status)
// ---------------------------------------------------------------------------
interface icache_mem_arbiter_if #(
    parameter int unsigned NCPU = 2
);
    import cpu_types_pkg::*;

    logic  [NCPU-1:0] iREN;
    word_t [NCPU-1:0] iaddr;
    logic  [NCPU-1:0] iwait;
    word_t [NCPU-1:0] iload;
    logic             dbusy;
    logic             ramREN;
    word_t            ramaddr;
    word_t            ramload;
    ramstate_t        ramstate;

    modport slave (
        input  iREN, iaddr, dbusy, ramload, ramstate,
        output iwait, iload, ramREN, ramaddr
    );

    modport master (
        output iREN, iaddr, dbusy, ramload, ramstate,
        input  iwait, iload, ramREN, ramaddr
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker.
//   Parameter NCPU : number of requesters.
//   Ports:
//     req   in  [NCPU]  request vector
//     ptr   in  [IDW]   index of the last granted requester
//     grant out [IDW]   first requester after ptr (wrapping NCPU-1 -> 0)
//     valid out         any request present
// ---------------------------------------------------------------------------
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter  int unsigned NCPU = 2,
    localparam int unsigned IDW  = id_width(NCPU)
) (
    input  logic [NCPU-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            valid
);

    logic [IDW-1:0] cand;

    // Scan ptr+1, ptr+2, ..., ptr+NCPU (mod NCPU); the last candidate is
    // ptr itself, so a lone requester that just won is granted again.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NCPU; i++) begin
            cand = IDW'((32'(ptr) + i) % NCPU);
            if (!valid && req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// icache_mem_arbiter
//   Responder end of the instruction side of cache_control_if. Arbitrates
//   the icache fetch requests round-robin, issues one RAM read at a time and
//   returns data with a single-cycle iwait-low / iload pulse. Backs off
//   whenever the data side holds RAM (dbusy).
//   Parameters:
//     NCPU    number of icache requesters (1..4)
//     RST_PTR reset value of the last-grant pointer (NCPU-1 -> CPU0 first)
//   Ports:
//     CLK   in   clock, rising edge
//     RST   in   asynchronous active-high reset
//     bus   slave modport of icache_mem_arbiter_if
//   Optional (macro IARB_PERF_EN):
//     grant_cnt out [NCPU]x32  saturating per-CPU delivery count
//     stall_cnt out 32         saturating count of cycles with a request
//                              pending and no delivery
// ---------------------------------------------------------------------------
module icache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCPU    = 2,
    parameter int unsigned RST_PTR = NCPU - 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    icache_mem_arbiter_if.slave  bus
`ifdef IARB_PERF_EN
    ,
    output word_t [NCPU-1:0]     grant_cnt,
    output word_t                stall_cnt
`endif
);

    localparam int unsigned IDW = id_width(NCPU);

    arb_state_t     state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] id, id_nxt;
    word_t          addr, addr_nxt;

    logic [IDW-1:0] rr_grant;
    logic           rr_valid;
    logic           abort;

    rr_arbiter #(
        .NCPU (NCPU)
    ) u_rr (
        .req   (bus.iREN),
        .ptr   (ptr),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= IDW'(RST_PTR);
            id    <= '0;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            id    <= id_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        id_nxt       = id;
        addr_nxt     = addr;
        bus.ramREN   = 1'b0;
        bus.ramaddr  = '0;
        bus.iwait    = '1;
        bus.iload    = '0;

        // Any of these cancels an in-flight fetch without moving the
        // pointer; a changed address is simply re-arbitrated from IDLE.
        abort = bus.dbusy || !bus.iREN[id] || (bus.iaddr[id] != addr);

        unique case (state)
            IDLE: begin
                if (!bus.dbusy && rr_valid) begin
                    id_nxt    = rr_grant;
                    addr_nxt  = bus.iaddr[rr_grant];
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                bus.ramREN  = !bus.dbusy;
                bus.ramaddr = addr;
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    case (bus.ramstate)
                        ACCESS: begin
                            bus.iwait[id] = 1'b0;
                            bus.iload[id] = bus.ramload;
                            ptr_nxt       = id;
                            state_nxt     = IDLE;
                        end
                        ERROR:   state_nxt = RETRY;
                        default: state_nxt = FETCH;
                    endcase
                end
            end

            RETRY: begin
                bus.ramaddr = addr;
                state_nxt   = abort ? IDLE : FETCH;
            end

            default: state_nxt = IDLE;
        endcase
    end

`ifdef IARB_PERF_EN
    logic deliver;
    assign deliver = (state == FETCH) && !abort && (bus.ramstate == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (deliver && (grant_cnt[id] != '1))
                grant_cnt[id] <= grant_cnt[id] + 32'd1;
            if ((|bus.iREN) && !deliver && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_icache_mem_arbiter
//   Self-checking bench for icache_mem_arbiter (NCPU = 2). Each scenario task
//   drives requests/RAM status and checks the RAM-side outputs inline; every
//   expected iwait/iload delivery is queued when the RAM is told to return
//   data and is popped by the negedge monitor when a pulse appears.
//   The RAM returns ramaddr ^ MASK unless a fixed word is forced.
// ---------------------------------------------------------------------------
module tb_icache_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned NCPU = 2;
    localparam word_t       MASK = 32'h5A5A_0000;

    typedef struct {
        int    cpu;
        word_t data;
    } exp_t;

    logic  CLK = 1'b0;
    logic  RST;
    logic  ld_fixed;
    word_t ld_val;
    exp_t  sb[$];
    exp_t  mon_e;
    int    n_cmp  = 0;
    int    n_fail = 0;

    always #5 CLK = ~CLK;

    icache_mem_arbiter_if #(.NCPU(NCPU)) bus ();

`ifdef IARB_PERF_EN
    word_t [NCPU-1:0] grant_cnt;
    word_t            stall_cnt;
`endif

    icache_mem_arbiter #(
        .NCPU    (NCPU),
        .RST_PTR (NCPU - 1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
`ifdef IARB_PERF_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always_comb bus.ramload = ld_fixed ? ld_val : (bus.ramaddr ^ MASK);

    // Delivery monitor: every iwait-low must match the head of the queue;
    // idle lanes must keep iload at zero.
    always @(negedge CLK) begin
        if (RST === 1'b0) begin
            for (int k = 0; k < NCPU; k++) begin
                n_cmp++;
                if (bus.iwait[k] === 1'b0) begin
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_delivery cpu%0d got iload=%h required no pulse", k, bus.iload[k]);
                    end else begin
                        mon_e = sb.pop_front();
                        if (mon_e.cpu != k || bus.iload[k] !== mon_e.data) begin
                            n_fail++;
                            $display("FAIL delivery got cpu%0d/%h required cpu%0d/%h", k, bus.iload[k], mon_e.cpu, mon_e.data);
                        end
                    end
                end else if (bus.iload[k] !== 32'h0) begin
                    n_fail++;
                    $display("FAIL idle_iload cpu%0d got %h required 00000000", k, bus.iload[k]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL rst_iwait got %b required 11", bus.iwait); end
        n_cmp++; if (bus.iload !== '0) begin n_fail++; $display("FAIL rst_iload got %h required 0", bus.iload); end
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL rst_ramREN got %b required 0", bus.ramREN); end
        n_cmp++; if (bus.ramaddr !== 32'h0) begin n_fail++; $display("FAIL rst_ramaddr got %h required 0", bus.ramaddr); end
        next_cycle();
        next_cycle();
        RST = 1'b0;
    endtask

    task automatic test_single_fetch();
        next_cycle();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h40; bus.ramstate = FREE;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL single_idle_ren got %b required 0", bus.ramREN); end
        for (int b = 0; b < 3; b++) begin
            next_cycle();
            bus.ramstate = BUSY;
            #1;
            n_cmp++; if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL single_busy%0d_ren got %b required 1", b, bus.ramREN); end
            n_cmp++; if (bus.ramaddr !== 32'h40) begin n_fail++; $display("FAIL single_busy%0d_addr got %h required 00000040", b, bus.ramaddr); end
            n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL single_busy%0d_iwait got %b required 11", b, bus.iwait); end
        end
        next_cycle();
        bus.ramstate = ACCESS; ld_fixed = 1'b1; ld_val = 32'hDEADBEEF;
        sb.push_back('{cpu: 0, data: 32'hDEADBEEF});
        #1;
        n_cmp++; if (bus.iwait !== 2'b10) begin n_fail++; $display("FAIL single_access_iwait got %b required 10", bus.iwait); end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE; ld_fixed = 1'b0;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL single_after_ren got %b required 0", bus.ramREN); end
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL single_after_iwait got %b required 11", bus.iwait); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL single_pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_fairness();
        word_t a [2];
        int    cpu;
        a[0] = 32'h100; a[1] = 32'h200;
        next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        bus.iREN = 2'b11; bus.iaddr[0] = a[0]; bus.iaddr[1] = a[1]; bus.ramstate = ACCESS;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL fair_idle0_ren got %b required 0", bus.ramREN); end
        for (int g = 0; g < 4; g++) begin
            if (g != 0) begin
                next_cycle();
                #1;
                n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL fair_idle%0d_ren got %b required 0", g, bus.ramREN); end
                n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL fair_idle%0d_iwait got %b required 11", g, bus.iwait); end
            end
            next_cycle();
            cpu = g % 2;
            sb.push_back('{cpu: cpu, data: a[cpu] ^ MASK});
            #1;
            n_cmp++; if (bus.ramREN !== 1'b1) begin n_fail++; $display("FAIL fair_fetch%0d_ren got %b required 1", g, bus.ramREN); end
            n_cmp++; if (bus.ramaddr !== a[cpu]) begin n_fail++; $display("FAIL fair_fetch%0d_addr got %h required %h", g, bus.ramaddr, a[cpu]); end
        end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL fair_end_ren got %b required 0", bus.ramREN); end
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL fair_pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_abandon();
        next_cycle();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h50; bus.ramstate = ACCESS;
        #1;
        next_cycle();
        sb.push_back('{cpu: 0, data: 32'h50 ^ MASK});
        #1;
        n_cmp++; if (bus.ramaddr !== 32'h50) begin n_fail++; $display("FAIL aband_pre_addr got %h required 00000050", bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h300; bus.ramstate = BUSY;
        #1;
        next_cycle();
        #1;
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h300) begin n_fail++; $display("FAIL aband_fetch got %b/%h required 1/00000300", bus.ramREN, bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b00;
        #1;
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL aband_drop_iwait got %b required 11", bus.iwait); end
        next_cycle();
        bus.iREN = 2'b11;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL aband_fall_ren got %b required 0", bus.ramREN); end
        next_cycle();
        bus.ramstate = ACCESS;
        sb.push_back('{cpu: 1, data: 32'h300 ^ MASK});
        #1;
        n_cmp++; if (bus.ramaddr !== 32'h300) begin n_fail++; $display("FAIL aband_regrant_addr got %h required 00000300", bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE;
        #1;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL aband_pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_preempt();
        next_cycle();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h80; bus.ramstate = ACCESS;
        #1;
        next_cycle();
        bus.dbusy = 1'b1;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL pre_dbusy_ren got %b required 0", bus.ramREN); end
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL pre_dbusy_iwait got %b required 11", bus.iwait); end
        next_cycle();
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL pre_hold_ren got %b required 0", bus.ramREN); end
        next_cycle();
        bus.dbusy = 1'b0;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL pre_release_ren got %b required 0", bus.ramREN); end
        next_cycle();
        sb.push_back('{cpu: 0, data: 32'h80 ^ MASK});
        #1;
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h80) begin n_fail++; $display("FAIL pre_regrant got %b/%h required 1/00000080", bus.ramREN, bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE;
        #1;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL pre_pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_error();
        next_cycle();
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h1C0; bus.ramstate = ERROR;
        #1;
        next_cycle();
        #1;
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h1C0) begin n_fail++; $display("FAIL err_fetch got %b/%h required 1/000001c0", bus.ramREN, bus.ramaddr); end
        next_cycle();
        bus.ramstate = FREE;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL err_retry_ren got %b required 0", bus.ramREN); end
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL err_retry_iwait got %b required 11", bus.iwait); end
        next_cycle();
        bus.ramstate = ACCESS;
        sb.push_back('{cpu: 1, data: 32'h1C0 ^ MASK});
        #1;
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h1C0) begin n_fail++; $display("FAIL err_reissue got %b/%h required 1/000001c0", bus.ramREN, bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE;
        #1;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL err_pending got %0d required 0", sb.size()); end
    endtask

    task automatic test_async_reset();
        next_cycle();
        bus.iREN = 2'b01; bus.iaddr[0] = 32'h200; bus.ramstate = ACCESS;
        #1;
        next_cycle();
        sb.push_back('{cpu: 0, data: 32'h200 ^ MASK});
        #1;
        next_cycle();
        bus.iREN = 2'b10; bus.iaddr[1] = 32'h240; bus.ramstate = BUSY;
        #1;
        next_cycle();
        #1;
        n_cmp++; if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h240) begin n_fail++; $display("FAIL ars_fetch got %b/%h required 1/00000240", bus.ramREN, bus.ramaddr); end
        #1;
        RST = 1'b1;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL ars_ren got %b required 0", bus.ramREN); end
        n_cmp++; if (bus.iwait !== 2'b11) begin n_fail++; $display("FAIL ars_iwait got %b required 11", bus.iwait); end
        n_cmp++; if (bus.ramaddr !== 32'h0) begin n_fail++; $display("FAIL ars_addr got %h required 0", bus.ramaddr); end
        next_cycle();
        RST = 1'b0;
        bus.iREN = 2'b11; bus.iaddr[0] = 32'h280;
        #1;
        n_cmp++; if (bus.ramREN !== 1'b0) begin n_fail++; $display("FAIL ars_idle_ren got %b required 0", bus.ramREN); end
        next_cycle();
        bus.ramstate = ACCESS;
        sb.push_back('{cpu: 0, data: 32'h280 ^ MASK});
        #1;
        n_cmp++; if (bus.ramaddr !== 32'h280) begin n_fail++; $display("FAIL ars_first_grant got %h required 00000280", bus.ramaddr); end
        next_cycle();
        bus.iREN = 2'b00; bus.ramstate = FREE;
        #1;
        n_cmp++; if (sb.size() != 0) begin n_fail++; $display("FAIL ars_pending got %0d required 0", sb.size()); end
    endtask

    initial begin
        RST          = 1'b1;
        bus.iREN     = '0;
        bus.iaddr    = '0;
        bus.dbusy    = 1'b0;
        bus.ramstate = FREE;
        ld_fixed     = 1'b0;
        ld_val       = '0;

        test_reset();
        test_single_fetch();
        test_fairness();
        test_abandon();
        test_preempt();
        test_error();
        test_async_reset();

        next_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
